sfp_tx_arbiter: RTL and testbench

Shares the single 64-bit SFP (Aurora) TX AXI-Stream between three requesters:
- Master command path (cmd).
- Peer-response FIFO (peer).
- Local telemetry FIFO (local).

The block grants one source at a time, in bursts, through a one-beat output register. It gates everything on link state. It replaces ad-hoc fixed-slot draining of the peer and local FIFOs, and exposes grant and statistics status to the PS.

---
 rtl/sfp_tx_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sfp_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_tx_arbiter.sv
// Burst arbiter sharing the 64-bit SFP/Aurora TX stream between cmd, peer and local sources.
// Optional starvation override is compiled in with `define SFP_TX_ARB_STARVE_EN.
module sfp_tx_arbiter #(
    parameter int MAX_BURST = 16
`ifdef SFP_TX_ARB_STARVE_EN
    ,
    parameter int STARVE_LIMIT = 1024
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_channel_up,
    input  logic        i_arb_en,
    input  logic [63:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    input  logic [63:0] s_peer_tdata,
    input  logic        s_peer_tvalid,
    output logic        s_peer_tready,
    input  logic [63:0] s_local_tdata,
    input  logic        s_local_tvalid,
    output logic        s_local_tready,
    output logic [63:0] m_tx_sfp_tdata,
    output logic        m_tx_sfp_tvalid,
    input  logic        m_tx_sfp_tready,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_arb_state,
    output logic [31:0] o_beat_cnt,
    output logic [15:0] o_drop_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        G_CMD   = 3'd1,
        G_PEER  = 3'd2,
        G_LOCAL = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t      state;
    logic        rr_local;
    logic [7:0]  burst_cnt;
    logic        out_free;
    logic        gnt_ready;
    logic        cur_valid;
    logic        gnt_empty;
    logic        cmd_acc;
    logic        peer_acc;
    logic        local_acc;
    logic        any_acc;
    logic [63:0] acc_data;
    logic        peer_starved;
    logic        local_starved;

    // Handshake: a beat moves when tvalid && tready are both high at a rising
    // edge; tvalid never waits on tready and tdata holds while tvalid && ~tready.
    assign out_free       = ~m_tx_sfp_tvalid | m_tx_sfp_tready;
    assign s_cmd_tready   = (state == G_CMD)   && i_channel_up && out_free;
    assign s_peer_tready  = (state == G_PEER)  && i_channel_up && out_free;
    assign s_local_tready = (state == G_LOCAL) && i_channel_up && out_free;

    assign cmd_acc   = s_cmd_tvalid   && s_cmd_tready;
    assign peer_acc  = s_peer_tvalid  && s_peer_tready;
    assign local_acc = s_local_tvalid && s_local_tready;
    assign any_acc   = cmd_acc | peer_acc | local_acc;

    always_comb begin
        acc_data  = s_cmd_tdata;
        cur_valid = 1'b0;
        gnt_ready = 1'b0;
        case (state)
            G_CMD: begin
                cur_valid = s_cmd_tvalid;
                gnt_ready = s_cmd_tready;
            end
            G_PEER: begin
                acc_data  = s_peer_tdata;
                cur_valid = s_peer_tvalid;
                gnt_ready = s_peer_tready;
            end
            G_LOCAL: begin
                acc_data  = s_local_tdata;
                cur_valid = s_local_tvalid;
                gnt_ready = s_local_tready;
            end
            default: begin
                acc_data  = s_cmd_tdata;
                cur_valid = 1'b0;
                gnt_ready = 1'b0;
            end
        endcase
    end

    // Granted source had a slot offered but nothing to send: end the grant.
    assign gnt_empty = gnt_ready && ~cur_valid;

`ifdef SFP_TX_ARB_STARVE_EN
    localparam logic [15:0] STARVE_LIM = 16'(STARVE_LIMIT);

    logic [15:0] peer_wait;
    logic [15:0] local_wait;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            peer_wait  <= 16'd0;
            local_wait <= 16'd0;
        end else begin
            if (state == G_PEER)
                peer_wait <= 16'd0;
            else if (s_peer_tvalid && peer_wait != 16'hFFFF)
                peer_wait <= peer_wait + 16'd1;
            if (state == G_LOCAL)
                local_wait <= 16'd0;
            else if (s_local_tvalid && local_wait != 16'hFFFF)
                local_wait <= local_wait + 16'd1;
        end
    end

    assign peer_starved  = s_peer_tvalid  && (peer_wait  >= STARVE_LIM);
    assign local_starved = s_local_tvalid && (local_wait >= STARVE_LIM);
`else
    assign peer_starved  = 1'b0;
    assign local_starved = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= IDLE;
            rr_local        <= 1'b0;
            burst_cnt       <= 8'd0;
            m_tx_sfp_tdata  <= 64'd0;
            m_tx_sfp_tvalid <= 1'b0;
            o_beat_cnt      <= 32'd0;
            o_drop_cnt      <= 16'd0;
        end else if (!i_channel_up) begin
            // Link lost: a beat still waiting on Aurora is discarded and counted.
            state <= FLUSH;
            if (m_tx_sfp_tvalid) begin
                m_tx_sfp_tvalid <= 1'b0;
                if (m_tx_sfp_tready)
                    o_beat_cnt <= o_beat_cnt + 32'd1;
                else if (o_drop_cnt != 16'hFFFF)
                    o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end else begin
            if (m_tx_sfp_tvalid && m_tx_sfp_tready)
                o_beat_cnt <= o_beat_cnt + 32'd1;

            if (any_acc) begin
                m_tx_sfp_tdata  <= acc_data;
                m_tx_sfp_tvalid <= 1'b1;
            end else if (m_tx_sfp_tready) begin
                m_tx_sfp_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_arb_en) begin
                        if (peer_starved) begin
                            state     <= G_PEER;
                            burst_cnt <= 8'd0;
                            rr_local  <= 1'b1;
                        end else if (local_starved) begin
                            state     <= G_LOCAL;
                            burst_cnt <= 8'd0;
                            rr_local  <= 1'b0;
                        end else if (s_cmd_tvalid) begin
                            state <= G_CMD;
                        end else if (s_peer_tvalid && (!rr_local || !s_local_tvalid)) begin
                            state     <= G_PEER;
                            burst_cnt <= 8'd0;
                            rr_local  <= 1'b1;
                        end else if (s_local_tvalid) begin
                            state     <= G_LOCAL;
                            burst_cnt <= 8'd0;
                            rr_local  <= 1'b0;
                        end
                    end
                end
                G_CMD: begin
                    if (cmd_acc || gnt_empty)
                        state <= IDLE;
                end
                G_PEER, G_LOCAL: begin
                    if (any_acc) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_cnt == BURST_LAST)
                            state <= IDLE;
                    end else if (gnt_empty) begin
                        state <= IDLE;
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_arb_state = state;
    assign o_grant     = {state == G_LOCAL, state == G_PEER, state == G_CMD};

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Directed bench for sfp_tx_arbiter: bench-side FIFO models, an in-order output
// scoreboard and a grant/burst log checked against hand-derived sequences.
`timescale 1ns/1ps
module tb_sfp_tx_arbiter;

    localparam logic [63:0] PEER_TAG  = 64'h5000_0000_0000_0000;
    localparam logic [63:0] LOCAL_TAG = 64'h4C00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        channel_up;
    logic        arb_en;
    logic [63:0] s_cmd_tdata;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [63:0] s_peer_tdata;
    logic        s_peer_tvalid;
    logic        s_peer_tready;
    logic [63:0] s_local_tdata;
    logic        s_local_tvalid;
    logic        s_local_tready;
    logic [63:0] m_tx_sfp_tdata;
    logic        m_tx_sfp_tvalid;
    logic        tx_tready;
    logic [2:0]  o_grant;
    logic [2:0]  o_arb_state;
    logic [31:0] o_beat_cnt;
    logic [15:0] o_drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    int peer_idx   = 0;
    int peer_left  = 0;
    int local_idx  = 0;
    int local_left = 0;
    logic cmd_flood = 1'b0;
    logic mon_en    = 1'b1;
    logic cmd_take, peer_take, local_take;

    logic [63:0] exp_q[$];
    logic [2:0]  gsrc_q[$];
    int          glen_q[$];
    logic [2:0]  prev_grant = 3'd0;
    int          run_len    = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign s_peer_tvalid  = (peer_left > 0);
    assign s_peer_tdata   = PEER_TAG | 64'(peer_idx);
    assign s_local_tvalid = (local_left > 0);
    assign s_local_tdata  = LOCAL_TAG | 64'(local_idx);

    sfp_tx_arbiter #(
        .MAX_BURST(16)
`ifdef SFP_TX_ARB_STARVE_EN
        ,
        .STARVE_LIMIT(40)
`endif
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_channel_up   (channel_up),
        .i_arb_en       (arb_en),
        .s_cmd_tdata    (s_cmd_tdata),
        .s_cmd_tvalid   (s_cmd_tvalid),
        .s_cmd_tready   (s_cmd_tready),
        .s_peer_tdata   (s_peer_tdata),
        .s_peer_tvalid  (s_peer_tvalid),
        .s_peer_tready  (s_peer_tready),
        .s_local_tdata  (s_local_tdata),
        .s_local_tvalid (s_local_tvalid),
        .s_local_tready (s_local_tready),
        .m_tx_sfp_tdata (m_tx_sfp_tdata),
        .m_tx_sfp_tvalid(m_tx_sfp_tvalid),
        .m_tx_sfp_tready(tx_tready),
        .o_grant        (o_grant),
        .o_arb_state    (o_arb_state),
        .o_beat_cnt     (o_beat_cnt),
        .o_drop_cnt     (o_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [2:0] g, input int budget);
        int n = 0;
        while (o_grant !== g && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < budget), 1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || peer_left != 0 || local_left != 0 ||
                s_cmd_tvalid || m_tx_sfp_tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    // FIFO models advance after each accepted beat
    always @(posedge clk) begin
        #1;
        if (cmd_take) begin
            if (cmd_flood) s_cmd_tdata = s_cmd_tdata + 64'd1;
            else           s_cmd_tvalid = 1'b0;
        end
        if (peer_take) begin
            peer_idx++;
            peer_left--;
        end
        if (local_take) begin
            local_idx++;
            local_left--;
        end
    end

    // scoreboard and grant log, sampled mid-cycle
    always @(negedge clk) begin
        cmd_take   = s_cmd_tvalid   && s_cmd_tready;
        peer_take  = s_peer_tvalid  && s_peer_tready;
        local_take = s_local_tvalid && s_local_tready;
        if (m_tx_sfp_tvalid && tx_tready && mon_en) begin
            chk("tx_beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("tx_data", m_tx_sfp_tdata, exp_q.pop_front());
        end
        if (o_grant != prev_grant) begin
            if (prev_grant != 3'd0) begin
                gsrc_q.push_back(prev_grant);
                glen_q.push_back(run_len);
            end
            run_len = 0;
        end
        if (cmd_take || peer_take || local_take) run_len++;
        prev_grant = o_grant;
    end

    initial begin
        int w;
        logic [63:0] hold_exp;
        rst_n        = 1'b0;
        channel_up   = 1'b1;
        arb_en       = 1'b1;
        tx_tready    = 1'b1;
        s_cmd_tdata  = 64'd0;
        s_cmd_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", o_arb_state, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_tvalid", m_tx_sfp_tvalid, 0);
        chk("rst_tdata", m_tx_sfp_tdata, 0);
        chk("rst_beat_cnt", o_beat_cnt, 0);
        chk("rst_drop_cnt", o_drop_cnt, 0);
        chk("rst_readies", {s_cmd_tready, s_peer_tready, s_local_tready}, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", o_arb_state, 0);

        // T1: single cmd beat, lands two cycles after the IDLE decision
        tick();
        s_cmd_tdata  = 64'h1100_0001_0000_00AA;
        s_cmd_tvalid = 1'b1;
        exp_q.push_back(64'h1100_0001_0000_00AA);
        @(posedge clk);
        @(negedge clk);
        chk("t1_state_gcmd", o_arb_state, 1);
        chk("t1_grant_cmd", o_grant, 3'b001);
        chk("t1_cmd_tready", s_cmd_tready, 1);
        @(negedge clk);
        chk("t1_tvalid", m_tx_sfp_tvalid, 1);
        chk("t1_tdata", m_tx_sfp_tdata, 64'h1100_0001_0000_00AA);
        chk("t1_back_idle", o_grant, 0);
        @(negedge clk);
        chk("t1_beat_cnt", o_beat_cnt, 1);
        chk("t1_tvalid_clr", m_tx_sfp_tvalid, 0);
        drain("t1_drain", 50);

        // T2: 40 peer beats -> bursts 16,16,8
        gsrc_q.delete();
        glen_q.delete();
        for (int i = 0; i < 40; i++) exp_q.push_back(PEER_TAG | 64'(i));
        tick();
        peer_idx  = 0;
        peer_left = 40;
        drain("t2_drain", 300);
        chk("t2_beat_cnt", o_beat_cnt, 41);
        chk("t2_num_bursts", glen_q.size(), 3);
        chk("t2_b0", {gsrc_q[0], 8'(glen_q[0])}, {3'b010, 8'd16});
        chk("t2_b1", {gsrc_q[1], 8'(glen_q[1])}, {3'b010, 8'd16});
        chk("t2_b2", {gsrc_q[2], 8'(glen_q[2])}, {3'b010, 8'd8});

        // T3: peer and local both loaded, round-robin now points at local; cmd mid-burst
        gsrc_q.delete();
        glen_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(LOCAL_TAG | 64'(i));
        exp_q.push_back(64'h1100_0002_0000_00BB);
        for (int i = 0; i < 16; i++) exp_q.push_back(PEER_TAG | 64'(i));
        for (int i = 16; i < 24; i++) exp_q.push_back(LOCAL_TAG | 64'(i));
        for (int i = 16; i < 24; i++) exp_q.push_back(PEER_TAG | 64'(i));
        tick();
        peer_idx   = 0;
        peer_left  = 24;
        local_idx  = 0;
        local_left = 24;
        wait_grant("t3_local_first", 3'b100, 20);
        repeat (4) @(negedge clk);
        tick();
        s_cmd_tdata  = 64'h1100_0002_0000_00BB;
        s_cmd_tvalid = 1'b1;
        drain("t3_drain", 300);
        chk("t3_beat_cnt", o_beat_cnt, 90);
        chk("t3_num_bursts", glen_q.size(), 5);
        chk("t3_b0", {gsrc_q[0], 8'(glen_q[0])}, {3'b100, 8'd16});
        chk("t3_b1", {gsrc_q[1], 8'(glen_q[1])}, {3'b001, 8'd1});
        chk("t3_b2", {gsrc_q[2], 8'(glen_q[2])}, {3'b010, 8'd16});
        chk("t3_b3", {gsrc_q[3], 8'(glen_q[3])}, {3'b100, 8'd8});
        chk("t3_b4", {gsrc_q[4], 8'(glen_q[4])}, {3'b010, 8'd8});

        // T4: Aurora backpressure for 5 cycles mid-burst
        for (int i = 0; i < 10; i++) exp_q.push_back(PEER_TAG | 64'(i));
        tick();
        peer_idx  = 0;
        peer_left = 10;
        wait_grant("t4_grant_peer", 3'b010, 20);
        repeat (3) @(negedge clk);
        tick();
        tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) hold_exp = PEER_TAG | 64'(peer_idx - 1);
            chk("t4_hold_tvalid", m_tx_sfp_tvalid, 1);
            chk("t4_hold_tdata", m_tx_sfp_tdata, hold_exp);
            chk("t4_src_tready", s_peer_tready, 0);
        end
        tick();
        tx_tready = 1'b1;
        drain("t4_drain", 100);
        chk("t4_beat_cnt", o_beat_cnt, 100);

        // T5: link loss with a beat pending; beat 0 is dropped, 1..5 follow after recovery
        for (int i = 1; i < 6; i++) exp_q.push_back(PEER_TAG | 64'(i));
        tick();
        tx_tready = 1'b0;
        peer_idx  = 0;
        peer_left = 6;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!m_tx_sfp_tvalid && w < 20);
        chk("t5_pending", m_tx_sfp_tvalid, 1);
        tick();
        channel_up = 1'b0;
        @(negedge clk);
        chk("t5_tready_drop_same_cycle", s_peer_tready, 0);
        @(negedge clk);
        chk("t5_tvalid_cleared", m_tx_sfp_tvalid, 0);
        chk("t5_drop_cnt", o_drop_cnt, 1);
        chk("t5_state_flush", o_arb_state, 4);
        chk("t5_grant_none", o_grant, 0);
        tick();
        channel_up = 1'b1;
        tx_tready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_state_idle", o_arb_state, 0);
        drain("t5_drain", 100);
        chk("t5_beat_cnt", o_beat_cnt, 105);
        chk("t5_drop_final", o_drop_cnt, 1);

`ifdef SFP_TX_ARB_STARVE_EN
        // T6: cmd asked at every IDLE; local must still win once its wait counter hits the limit
        tick();
        mon_en       = 1'b0;
        cmd_flood    = 1'b1;
        s_cmd_tdata  = 64'h1100_0003_0000_0000;
        s_cmd_tvalid = 1'b1;
        local_idx    = 0;
        local_left   = 3;
        w = 0;
        while (o_grant !== 3'b100 && w < 200) begin
            @(negedge clk);
            if (o_grant !== 3'b100) w++;
        end
        chk("t6_local_granted", o_grant, 3'b100);
        chk("t6_wait_window", (w >= 40 && w <= 43), 1);
        chk("t6_cmd_pending", s_cmd_tvalid, 1);
        cmd_flood = 1'b0;
        drain("t6_drain", 200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
